// File: rtl/prime_pkg.sv
// Shared definitions for the prime scan sequencer, its front-end and the checker engine.
package prime_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACCUM,
    DONE
  } scan_state_e;

endpackage

// File: rtl/scan_watchdog.sv
// Saturating cycle counter that flags an engine which never answers within TIMEOUT wait cycles.
module scan_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the TIMEOUT-th consecutive run cycle.
  assign expired_o = run_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/prime_scan_ctrl.sv
// Sweeps candidates 2..limit through a single prime-checker engine and accumulates
// the prime count and the largest prime seen.
module prime_scan_ctrl
  import prime_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] limit_i,
  output logic              en_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              valid_i,
  input  logic              is_prime_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] last_prime_o
);

  localparam logic [DATA_W-1:0] FIRST_CAND = DATA_W'(2);

  scan_state_e       state_q, state_d;
  logic [DATA_W-1:0] lim_q;
  logic [DATA_W-1:0] cand_q;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] last_q;
  logic              verdict_q;
  logic              err_q;
  logic              busy_q;
  logic              done_q;
  logic              expired;
  logic              start_ok;

  assign start_ok = (state_q == IDLE) && start_i && !abort_i;

  scan_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == ISSUE),
    .run_i     (state_q == WAIT),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) state_d = (limit_i < FIRST_CAND) ? DONE : ISSUE;
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          // A verdict arriving in the final watchdog cycle still counts.
          if (valid_i)      state_d = ACCUM;
          else if (expired) state_d = DONE;
        end
        ACCUM: state_d = (cand_q == lim_q) ? DONE : ISSUE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lim_q     <= '0;
      cand_q    <= '0;
      count_q   <= '0;
      last_q    <= '0;
      verdict_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_d == ISSUE) || (state_d == WAIT) || (state_d == ACCUM);
      done_q <= (state_q == DONE) && !abort_i;
      if (start_ok) begin
        lim_q   <= limit_i;
        count_q <= '0;
        last_q  <= '0;
        err_q   <= 1'b0;
        if (limit_i >= FIRST_CAND) cand_q <= FIRST_CAND;
      end
      if ((state_q == WAIT) && !abort_i) begin
        if (valid_i)      verdict_q <= is_prime_i;
        else if (expired) err_q     <= 1'b1;
      end
      if ((state_q == ACCUM) && !abort_i) begin
        if (verdict_q) begin
          count_q <= count_q + 1'b1;
          last_q  <= cand_q;
        end
        // End test precedes the increment, so a full-range limit never wraps.
        if (cand_q != lim_q) cand_q <= cand_q + 1'b1;
      end
    end
  end

  always_comb begin
    en_o         = (state_q == ISSUE);
    data_o       = cand_q;
    busy_o       = busy_q;
    done_o       = done_q;
    err_o        = err_q;
    count_o      = count_q;
    last_prime_o = last_q;
  end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Directed bench for prime_scan_ctrl with a small behavioural prime engine.
module tb_prime_scan_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [DW-1:0] limit_i;
  logic          en_o;
  logic [DW-1:0] data_o;
  logic          valid_i;
  logic          is_prime_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [DW-1:0] count_o;
  logic [DW-1:0] last_prime_o;

  prime_scan_ctrl #(
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .limit_i      (limit_i),
    .en_o         (en_o),
    .data_o       (data_o),
    .valid_i      (valid_i),
    .is_prime_i   (is_prime_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .count_o      (count_o),
    .last_prime_o (last_prime_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++) begin
      if (n % k == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Engine model: answers 3 cycles after en_o unless told to stay silent on one candidate.
  int            silent = 1000;
  logic [DW-1:0] eng_d;
  initial begin
    valid_i    = 1'b0;
    is_prime_i = 1'b0;
    forever begin
      @(negedge clk);
      if (en_o && !rst && (int'(data_o) != silent)) begin
        eng_d = data_o;
        repeat (3) @(negedge clk);
        valid_i    = 1'b1;
        is_prime_i = is_prime(int'(eng_d));
        @(negedge clk);
        valid_i    = 1'b0;
        is_prime_i = 1'b0;
      end
    end
  end

  int            cyc        = 0;
  int            en_total   = 0;
  int            done_total = 0;
  int            seq_err    = 0;
  int            en5_cyc    = 0;
  int            done_cyc   = 0;
  logic [DW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (en_o) begin
      en_total  <= en_total + 1;
      prev_data <= data_o;
      if ((data_o != DW'(2)) && (data_o != prev_data + 1'b1)) seq_err <= seq_err + 1;
      if (data_o == DW'(5)) en5_cyc <= cyc;
    end
    if (done_o) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
  end

  task automatic pulse_start(input logic [DW-1:0] lim);
    @(negedge clk);
    limit_i = lim;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_en(input string tag, input logic [DW-1:0] val, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (en_o && data_o == val) seen = 1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  int en_base;
  int done_base;
  int seq_base;

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    limit_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_en",    32'(en_o),         32'd0);
    check_eq("rst_busy",  32'(busy_o),       32'd0);
    check_eq("rst_done",  32'(done_o),       32'd0);
    check_eq("rst_err",   32'(err_o),        32'd0);
    check_eq("rst_data",  32'(data_o),       32'd0);
    check_eq("rst_count", 32'(count_o),      32'd0);
    check_eq("rst_last",  32'(last_prime_o), 32'd0);
    rst = 1'b0;

    // limit 10: primes 2,3,5,7
    en_base = en_total; done_base = done_total; seq_base = seq_err;
    pulse_start(8'd10);
    check_eq("l10_first_en",   32'(en_o),   32'd1);
    check_eq("l10_first_data", 32'(data_o), 32'd2);
    check_eq("l10_busy",       32'(busy_o), 32'd1);
    wait_done("l10_done_seen", 500);
    repeat (3) @(negedge clk);
    check_eq("l10_count",   32'(count_o),          32'd4);
    check_eq("l10_last",    32'(last_prime_o),     32'd7);
    check_eq("l10_data",    32'(data_o),           32'd10);
    check_eq("l10_err",     32'(err_o),            32'd0);
    check_eq("l10_busy_end", 32'(busy_o),          32'd0);
    check_eq("l10_en_cnt",  32'(en_total - en_base),     32'd9);
    check_eq("l10_done_cnt", 32'(done_total - done_base), 32'd1);
    check_eq("l10_seq",     32'(seq_err - seq_base),     32'd0);

    // limits below 2 finish without touching the engine
    for (int l = 1; l >= 0; l--) begin
      en_base = en_total;
      pulse_start(DW'(l));
      check_eq("lsmall_done_early", 32'(done_o), 32'd0);
      check_eq("lsmall_busy",       32'(busy_o), 32'd0);
      @(negedge clk);
      check_eq("lsmall_done",       32'(done_o), 32'd1);
      @(negedge clk);
      check_eq("lsmall_done_pulse", 32'(done_o), 32'd0);
      check_eq("lsmall_count",      32'(count_o), 32'd0);
      check_eq("lsmall_last",       32'(last_prime_o), 32'd0);
      check_eq("lsmall_en",         32'(en_total - en_base), 32'd0);
    end

    // full range: 54 primes below 256, largest 251
    en_base = en_total; seq_base = seq_err;
    pulse_start(8'd255);
    wait_done("l255_done_seen", 4000);
    repeat (2) @(negedge clk);
    check_eq("l255_count", 32'(count_o),      32'd54);
    check_eq("l255_last",  32'(last_prime_o), 32'd251);
    check_eq("l255_data",  32'(data_o),       32'd255);
    check_eq("l255_en",    32'(en_total - en_base), 32'd254);
    check_eq("l255_seq",   32'(seq_err - seq_base), 32'd0);
    check_eq("l255_busy",  32'(busy_o),       32'd0);

    // engine silent on 5: timeout after 16 wait cycles
    silent = 5; done_base = done_total;
    pulse_start(8'd10);
    wait_done("to_done_seen", 500);
    repeat (2) @(negedge clk);
    check_eq("to_err",      32'(err_o),        32'd1);
    check_eq("to_count",    32'(count_o),      32'd2);
    check_eq("to_last",     32'(last_prime_o), 32'd3);
    check_eq("to_data",     32'(data_o),       32'd5);
    check_eq("to_latency",  32'(done_cyc - en5_cyc), 32'd18);
    check_eq("to_done_cnt", 32'(done_total - done_base), 32'd1);
    silent = 1000;
    pulse_start(8'd0);
    check_eq("to_err_clear", 32'(err_o), 32'd0);
    repeat (3) @(negedge clk);

    // abort while waiting on 6, then a stale verdict
    silent = 6; done_base = done_total;
    pulse_start(8'd10);
    wait_en("ab_en6", DW'(6), 500);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_eq("ab_busy",  32'(busy_o),  32'd0);
    check_eq("ab_count", 32'(count_o), 32'd3);
    valid_i = 1'b1; is_prime_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; is_prime_i = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("ab_late_count", 32'(count_o),      32'd3);
    check_eq("ab_late_last",  32'(last_prime_o), 32'd5);
    check_eq("ab_no_done",    32'(done_total - done_base), 32'd0);
    check_eq("ab_no_en",      32'(en_o),         32'd0);
    silent = 1000;

    // start re-pulsed with a new limit mid-scan
    en_base = en_total;
    pulse_start(8'd10);
    wait_en("rs_en4", DW'(4), 500);
    limit_i = 8'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("rs_done_seen", 500);
    repeat (2) @(negedge clk);
    check_eq("rs_count", 32'(count_o),      32'd4);
    check_eq("rs_last",  32'(last_prime_o), 32'd7);
    check_eq("rs_en",    32'(en_total - en_base), 32'd9);

    // synchronous reset while in ACCUM
    silent = 3;
    pulse_start(8'd10);
    wait_en("rr_en3", DW'(3), 500);
    @(negedge clk);
    valid_i = 1'b1; is_prime_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; is_prime_i = 1'b0;
    check_eq("rr_pre_count", 32'(count_o), 32'd1);
    check_eq("rr_pre_busy",  32'(busy_o),  32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rr_count", 32'(count_o),      32'd0);
    check_eq("rr_last",  32'(last_prime_o), 32'd0);
    check_eq("rr_busy",  32'(busy_o),       32'd0);
    check_eq("rr_data",  32'(data_o),       32'd0);
    check_eq("rr_en",    32'(en_o),         32'd0);
    check_eq("rr_done",  32'(done_o),       32'd0);
    check_eq("rr_err",   32'(err_o),        32'd0);
    rst = 1'b0;
    silent = 1000;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
